pipe_power: RTL and testbench



---
 rtl/pipe_power_pkg.sv | 26 ++
 rtl/pipe_power_stage.sv | 62 ++++++
 rtl/pipe_power.sv | 103 ++++++++++
 tb/tb_pipe_power.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_power_pkg.sv
// pipe_power_pkg: shared types and helpers
// for the pipelined integer power unit.
package pipe_power_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MAX_EXP = 3;
  localparam int DEF_EXP_W   = 3;
  localparam int STAGES      = DEF_MAX_EXP + 1;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] base;
    logic [DEF_WIDTH-1:0] acc;
    logic [DEF_EXP_W-1:0] exp_c;
    logic                 ovf;
    logic                 err;
  } stage_t;

  function automatic int unsigned clamp_exp(
    input int unsigned e,
    input int unsigned m
  );
    return (e > m) ? m : e;
  endfunction

endpackage

// File: rtl/pipe_power_stage.sv
// pipe_power_stage: one multiply stage with its
// payload register and bubble-collapsing load.
module pipe_power_stage
  import pipe_power_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int EXP_W     = DEF_EXP_W,
  parameter int STAGE_IDX = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2*WIDTH+EXP_W+2:0] i_prev,
  input  logic                     i_next_load,
  output logic [2*WIDTH+EXP_W+2:0] o_cur
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] acc;
    logic [EXP_W-1:0] exp_c;
    logic             ovf;
    logic             err;
  } pl_t;

  localparam logic [EXP_W-1:0] L_IDX = EXP_W'(STAGE_IDX);

  pl_t                w_prev;
  pl_t                w_d;
  pl_t                r_q;
  logic               w_load;
  logic [2*WIDTH-1:0] w_prod;

  assign w_prev = i_prev;
  assign w_prod = (2*WIDTH)'(w_prev.acc)
                * (2*WIDTH)'(w_prev.base);
  assign w_load = !r_q.valid || i_next_load;
  assign o_cur  = r_q;

  // multiply only while this stage is within the
  // sample's exponent; bubbles load as all-zero
  always_comb begin
    w_d = w_prev;
    if (!w_prev.valid) begin
      w_d = '0;
    end else if (w_prev.exp_c >= L_IDX) begin
      w_d.acc = w_prod[WIDTH-1:0];
      w_d.ovf = w_prev.ovf
              | (|w_prod[2*WIDTH-1:WIDTH]);
    end
  end

  // payload register: loads when empty or draining
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (w_load) begin
      r_q <= w_d;
    end
  end

endmodule

// File: rtl/pipe_power.sv
// pipe_power: pipelined base^exp mod 2^WIDTH with
// valid/ready on both sides and overflow/clamp flags.
module pipe_power
  import pipe_power_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_EXP = DEF_MAX_EXP,
  parameter int EXP_W   = DEF_EXP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_base,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int PW = 2*WIDTH + EXP_W + 3;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] acc;
    logic [EXP_W-1:0] exp_c;
    logic             ovf;
    logic             err;
  } pl_t;

  pl_t            r_s0;
  pl_t            w_s0_d;
  logic           w_s0_load;
  logic [PW-1:0]  w_pl [0:MAX_EXP];
  logic [MAX_EXP:0] w_v;
  logic [MAX_EXP:0] w_dn;

  // stage k may advance if the sink is ready or any
  // later stage is empty (bubble collapse)
  always_comb begin
    logic l_go;
    l_go = out_ready;
    w_dn = '0;
    for (int k = MAX_EXP; k >= 0; k--) begin
      w_dn[k] = l_go;
      l_go    = l_go | ~w_v[k];
    end
  end

  assign w_s0_load = !r_s0.valid || w_dn[0];
  assign in_ready  = w_s0_load;

  // capture: clamp exponent, seed acc with 1
  always_comb begin
    w_s0_d = '0;
    if (in_valid) begin
      w_s0_d.valid = 1'b1;
      w_s0_d.base  = in_base;
      w_s0_d.acc   = WIDTH'(1);
      w_s0_d.exp_c = EXP_W'(clamp_exp(32'(in_exp),
                                      MAX_EXP));
      w_s0_d.err   = 32'(in_exp) > 32'(MAX_EXP);
    end
  end

  // capture register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s0 <= '0;
    end else if (w_s0_load) begin
      r_s0 <= w_s0_d;
    end
  end

  assign w_pl[0] = r_s0;

  for (genvar k = 1; k <= MAX_EXP; k++) begin : g_st
    pipe_power_stage #(
      .WIDTH    (WIDTH),
      .EXP_W    (EXP_W),
      .STAGE_IDX(k)
    ) u_st (
      .clock      (clock),
      .reset      (reset),
      .i_prev     (w_pl[k-1]),
      .i_next_load(w_dn[k]),
      .o_cur      (w_pl[k])
    );
  end

  for (genvar k = 0; k <= MAX_EXP; k++) begin : g_v
    assign w_v[k] = w_pl[k][PW-1];
  end

  assign out_valid  = w_pl[MAX_EXP][PW-1];
  assign out_result = w_pl[MAX_EXP][WIDTH+EXP_W+1:EXP_W+2];
  assign out_ovf    = w_pl[MAX_EXP][1];
  assign out_err    = w_pl[MAX_EXP][0];

endmodule

// File: tb/tb_pipe_power.sv
// tb_pipe_power: directed vector table plus
// backpressure and mid-flight reset sequences.
module tb_pipe_power;

  localparam int MAX_EXP = 3;

  typedef struct packed {
    logic [31:0] base;
    logic [2:0]  exp;
    logic [31:0] res;
    logic        ovf;
    logic        err;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_base;
  logic [2:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_err;

  pipe_power dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  int   n_out = 0;
  logic lat_chk = 1'b0;
  vec_t cur;
  vec_t q [$];
  int   qc [$];
  vec_t tab [21];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] b,
                              input logic [2:0]  e,
                              input logic [31:0] r,
                              input logic        o,
                              input logic        er);
    vec_t v;
    v.base = b; v.exp = e; v.res = r;
    v.ovf = o; v.err = er;
    return v;
  endfunction

  // scoreboard: compare head while valid, pop on
  // transfer, enqueue on accept
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          check("result", out_result, q[0].res);
          check("ovf", 32'(out_ovf), 32'(q[0].ovf));
          check("err", 32'(out_err), 32'(q[0].err));
          if (out_ready) begin
            if (lat_chk)
              check("latency", 32'(cyc - qc[0]),
                    32'(MAX_EXP));
            void'(q.pop_front());
            void'(qc.pop_front());
            n_out++;
          end
        end
      end else begin
        check("idle_flags", {30'd0, out_ovf, out_err},
              32'd0);
      end
      if (in_valid && in_ready) begin
        q.push_back(cur);
        qc.push_back(cyc + 1);
        n_acc++;
      end
    end
  end

  task automatic send(input vec_t v);
    int t;
    cur      = v;
    in_base  = v.base;
    in_exp   = v.exp;
    in_valid = 1'b1;
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 60 && q.size() > 0; t++)
      @(negedge clock);
    check(nm, 32'(q.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int a0;
    int o0;
    tab[0]  = mk(1, 3, 1, 0, 0);
    tab[1]  = mk(2, 3, 8, 0, 0);
    tab[2]  = mk(3, 3, 27, 0, 0);
    tab[3]  = mk(4, 3, 64, 0, 0);
    tab[4]  = mk(5, 3, 125, 0, 0);
    tab[5]  = mk(5, 0, 1, 0, 0);
    tab[6]  = mk(5, 1, 5, 0, 0);
    tab[7]  = mk(5, 2, 25, 0, 0);
    tab[8]  = mk(0, 0, 1, 0, 0);
    tab[9]  = mk(7, 3, 343, 0, 0);
    tab[10] = mk(2048, 3, 0, 1, 0);
    tab[11] = mk(1625, 3, 32'd4291015625, 0, 0);
    tab[12] = mk(65536, 2, 0, 1, 0);
    tab[13] = mk(2, 2, 4, 0, 0);
    tab[14] = mk(2, 7, 8, 0, 1);
    tab[15] = mk(2, 3, 8, 0, 0);
    tab[16] = mk(32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0);
    tab[17] = mk(32'hFFFFFFFF, 2, 1, 1, 0);
    tab[18] = mk(32'hFFFFFFFF, 3, 32'hFFFFFFFF, 1, 0);
    tab[19] = mk(0, 5, 0, 0, 1);
    tab[20] = mk(3, 4, 27, 0, 1);

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_base   = '0;
    in_exp    = '0;
    out_ready = 1'b1;
    cur       = '0;
    repeat (2) @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // back-to-back table at full throughput
    lat_chk = 1'b1;
    for (int i = 0; i < 21; i++) send(tab[i]);
    drain("table_drain");
    check("table_count", 32'(n_out), 32'd21);

    // backpressure: sink stalls while 10 cubes stream
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    a0 = n_acc;
    o0 = n_out;
    fork
      begin
        for (int b = 1; b <= 10; b++)
          send(mk(32'(b), 3, 32'(b * b * b), 0, 0));
      end
      begin
        repeat (8) @(negedge clock);
        check("stall_accepts", 32'(n_acc - a0), 32'd4);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_delivered", 32'(n_out - o0), 32'd10);

    // reset with three samples in flight
    send(mk(9, 3, 729, 0, 0));
    send(mk(4, 2, 16, 0, 0));
    send(mk(6, 1, 6, 0, 0));
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", out_result, 32'd0);
    q.delete();
    qc.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_idle", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;
    lat_chk = 1'b1;
    o0 = n_out;
    send(mk(3, 3, 27, 0, 0));
    drain("post_rst_drain");
    check("post_rst_count", 32'(n_out - o0), 32'd1);
    repeat (4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
